// File: rtl/ack_control_sequencer.sv
// Interrupt-acknowledge / poll control sequencer for an 8259A-style controller.
// Tracks INTA_n and read edges and drives the acknowledge control state, ISR latch, IRR freeze and captured vector.
module ack_control_sequencer (
  input  logic       clock,
  input  logic       reset,
  input  logic       interrupt_acknowledge_n,
  input  logic       read,
  input  logic       poll_command,
  input  logic       write_icw1,
  input  logic       u8086_or_mcs80_config,
  input  logic       cascade_slave,
  input  logic       cascade_slave_enable,
  input  logic [7:0] interrupt,
  output logic [2:0] control_state,
  output logic [7:0] interrupt_when_ack1,
  output logic       latch_in_service,
  output logic       freeze,
  output logic       end_of_acknowledge_sequence,
  output logic       end_of_poll_command
);

  typedef enum logic [2:0] {
    CTL_READY = 3'b000,
    ACK1      = 3'b001,
    ACK2      = 3'b010,
    ACK3      = 3'b011,
    POLL      = 3'b100
  } state_t;

  state_t     state_q, state_d;
  logic       inta_prev_q;
  logic       read_prev_q;
  logic [7:0] iwa1_q, iwa1_d;
  logic       freeze_q, freeze_d;
  logic       latch_q, latch_d;
  logic       eoa_q, eoa_d;
  logic       eop_q, eop_d;

  logic inta_fall, inta_rise, read_rise, read_fall;

  // A slave only claims the acknowledge when the CAS lines address it.
  function automatic logic ack_latch_ok(input logic [7:0] irq, input logic slave,
                                        input logic slave_en);
    return (irq != 8'h00) && (!slave || slave_en);
  endfunction

  always_comb begin
    inta_fall = inta_prev_q & ~interrupt_acknowledge_n;
    inta_rise = ~inta_prev_q & interrupt_acknowledge_n;
    read_rise = ~read_prev_q & read;
    read_fall = read_prev_q & ~read;
  end

  always_comb begin
    state_d  = state_q;
    iwa1_d   = iwa1_q;
    freeze_d = freeze_q;
    latch_d  = 1'b0;
    eoa_d    = 1'b0;
    eop_d    = 1'b0;
    case (state_q)
      CTL_READY: begin
        if (inta_fall) begin
          state_d  = ACK1;
          iwa1_d   = interrupt;
          freeze_d = 1'b1;
          latch_d  = ack_latch_ok(interrupt, cascade_slave, cascade_slave_enable);
        end else if (poll_command) begin
          state_d = POLL;
        end
      end
      ACK1: begin
        if (inta_rise) state_d = ACK2;
      end
      ACK2: begin
        if (inta_rise) begin
          if (u8086_or_mcs80_config) begin
            state_d = ACK3;
          end else begin
            state_d  = CTL_READY;
            freeze_d = 1'b0;
            eoa_d    = 1'b1;
          end
        end
      end
      ACK3: begin
        if (inta_rise) begin
          state_d  = CTL_READY;
          freeze_d = 1'b0;
          eoa_d    = 1'b1;
        end
      end
      POLL: begin
        // An INTA fall aborts the poll and starts a normal acknowledge.
        if (inta_fall) begin
          state_d  = ACK1;
          iwa1_d   = interrupt;
          freeze_d = 1'b1;
          latch_d  = ack_latch_ok(interrupt, cascade_slave, cascade_slave_enable);
        end else if (read_rise) begin
          iwa1_d  = interrupt;
          latch_d = (interrupt != 8'h00);
        end else if (read_fall) begin
          state_d = CTL_READY;
          eop_d   = 1'b1;
        end
      end
      default: begin
        state_d  = CTL_READY;
        freeze_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset || write_icw1) begin
      state_q     <= CTL_READY;
      inta_prev_q <= 1'b1;
      read_prev_q <= 1'b0;
      iwa1_q      <= 8'h00;
      freeze_q    <= 1'b0;
      latch_q     <= 1'b0;
      eoa_q       <= 1'b0;
      eop_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      inta_prev_q <= interrupt_acknowledge_n;
      read_prev_q <= read;
      iwa1_q      <= iwa1_d;
      freeze_q    <= freeze_d;
      latch_q     <= latch_d;
      eoa_q       <= eoa_d;
      eop_q       <= eop_d;
    end
  end

  assign control_state               = state_q;
  assign interrupt_when_ack1         = iwa1_q;
  assign latch_in_service            = latch_q;
  assign freeze                      = freeze_q;
  assign end_of_acknowledge_sequence = eoa_q;
  assign end_of_poll_command         = eop_q;

endmodule

// File: tb/tb_ack_control_sequencer.sv
// Directed, table-driven bench for ack_control_sequencer with a few hand-written multi-cycle sequences.
module tb_ack_control_sequencer;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       inta_n = 1'b1;
  logic       rd = 1'b0;
  logic       poll = 1'b0;
  logic       icw1 = 1'b0;
  logic       cfg = 1'b0;
  logic       cs = 1'b0;
  logic       cse = 1'b0;
  logic [7:0] irq = 8'h00;
  logic [2:0] st;
  logic [7:0] iwa;
  logic       lat, frz, eoa, eop;

  int errors = 0;
  int checks = 0;

  ack_control_sequencer dut (
    .clock                      (clock),
    .reset                      (reset),
    .interrupt_acknowledge_n    (inta_n),
    .read                       (rd),
    .poll_command               (poll),
    .write_icw1                 (icw1),
    .u8086_or_mcs80_config      (cfg),
    .cascade_slave              (cs),
    .cascade_slave_enable       (cse),
    .interrupt                  (irq),
    .control_state              (st),
    .interrupt_when_ack1        (iwa),
    .latch_in_service           (lat),
    .freeze                     (frz),
    .end_of_acknowledge_sequence(eoa),
    .end_of_poll_command        (eop)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic       rst, icw1, inta, rd, poll, cfg, cs, cse;
    logic [7:0] irq;
    logic [2:0] st;
    logic [7:0] iwa;
    logic       lat, frz, eoa, eop;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(logic r, logic w, logic a, logic d, logic p, logic c,
                              logic s, logic e, logic [7:0] i, logic [2:0] xs,
                              logic [7:0] xi, logic xl, logic xf, logic xa, logic xp);
    vec_t v;
    v.rst = r; v.icw1 = w; v.inta = a; v.rd = d; v.poll = p; v.cfg = c;
    v.cs = s; v.cse = e; v.irq = i; v.st = xs; v.iwa = xi;
    v.lat = xl; v.frz = xf; v.eoa = xa; v.eop = xp;
    return v;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [14:0] act, input logic [14:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got st/iwa/lat/frz/eoa/eop=%h required %h", name, act, exp);
    end
  endtask

  function automatic logic [14:0] outs();
    return {st, iwa, lat, frz, eoa, eop};
  endfunction

  initial begin
    //           rst w a d p c s e irq    st    iwa   l f a p
    vq.push_back(mk(1,0,1,0,0,0,0,0,8'h04,3'd0,8'h00,0,0,0,0)); // reset
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h04,3'd0,8'h00,0,0,0,0));
    // 8086 two-pulse sequence
    vq.push_back(mk(0,0,0,0,0,0,0,0,8'h04,3'd1,8'h04,1,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,8'h04,3'd1,8'h04,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,8'h04,3'd1,8'h04,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h04,3'd2,8'h04,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h04,3'd2,8'h04,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,8'h04,3'd2,8'h04,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,8'h04,3'd2,8'h04,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h04,3'd0,8'h04,0,0,1,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h04,3'd0,8'h04,0,0,0,0));
    // MCS-80 three-pulse sequence
    vq.push_back(mk(0,0,0,0,0,1,0,0,8'h80,3'd1,8'h80,1,1,0,0));
    vq.push_back(mk(0,0,1,0,0,1,0,0,8'h80,3'd2,8'h80,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,1,0,0,8'h80,3'd2,8'h80,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,1,0,0,8'h80,3'd3,8'h80,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,1,0,0,8'h80,3'd3,8'h80,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,1,0,0,8'h80,3'd0,8'h80,0,0,1,0));
    vq.push_back(mk(0,0,1,0,0,1,0,0,8'h80,3'd0,8'h80,0,0,0,0));
    // mode changed to 8086 before the ACK2 rise
    vq.push_back(mk(0,0,0,0,0,1,0,0,8'h02,3'd1,8'h02,1,1,0,0));
    vq.push_back(mk(0,0,1,0,0,1,0,0,8'h02,3'd2,8'h02,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,8'h02,3'd2,8'h02,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h02,3'd0,8'h02,0,0,1,0));
    // spurious acknowledge: nothing pending
    vq.push_back(mk(0,0,0,0,0,0,0,0,8'h00,3'd1,8'h00,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h00,3'd2,8'h00,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,8'h00,3'd2,8'h00,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h00,3'd0,8'h00,0,0,1,0));
    // unaddressed slave
    vq.push_back(mk(0,0,0,0,0,0,1,0,8'h01,3'd1,8'h01,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,1,0,8'h01,3'd2,8'h01,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,1,0,8'h01,3'd2,8'h01,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,1,0,8'h01,3'd0,8'h01,0,0,1,0));
    // addressed slave
    vq.push_back(mk(0,0,0,0,0,0,1,1,8'h01,3'd1,8'h01,1,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,1,1,8'h01,3'd2,8'h01,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,1,1,8'h01,3'd2,8'h01,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,1,1,8'h01,3'd0,8'h01,0,0,1,0));
    // poll read
    vq.push_back(mk(0,0,1,0,1,0,0,0,8'h10,3'd4,8'h01,0,0,0,0));
    vq.push_back(mk(0,0,1,1,0,0,0,0,8'h10,3'd4,8'h10,1,0,0,0));
    vq.push_back(mk(0,0,1,1,0,0,0,0,8'h10,3'd4,8'h10,0,0,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h10,3'd0,8'h10,0,0,0,1));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h10,3'd0,8'h10,0,0,0,0));
    // poll_command and INTA fall together: acknowledge wins
    vq.push_back(mk(0,0,0,0,1,0,0,0,8'h08,3'd1,8'h08,1,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h08,3'd2,8'h08,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,8'h08,3'd2,8'h08,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h08,3'd0,8'h08,0,0,1,0));
    // INTA fall aborts a poll in progress
    vq.push_back(mk(0,0,1,0,1,0,0,0,8'h20,3'd4,8'h08,0,0,0,0));
    vq.push_back(mk(0,0,1,1,0,0,0,0,8'h20,3'd4,8'h20,1,0,0,0));
    vq.push_back(mk(0,0,0,1,0,0,0,0,8'h20,3'd1,8'h20,1,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,8'h20,3'd1,8'h20,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h20,3'd2,8'h20,0,1,0,0));
    vq.push_back(mk(0,0,0,0,0,0,0,0,8'h20,3'd2,8'h20,0,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h20,3'd0,8'h20,0,0,1,0));
    // write_icw1 while in ACK2
    vq.push_back(mk(0,0,0,0,0,0,0,0,8'h40,3'd1,8'h40,1,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h40,3'd2,8'h40,0,1,0,0));
    vq.push_back(mk(0,1,1,0,0,0,0,0,8'h40,3'd0,8'h00,0,0,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h40,3'd0,8'h00,0,0,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h40,3'd0,8'h00,0,0,0,0));
    // reset while in ACK2
    vq.push_back(mk(0,0,0,0,0,0,0,0,8'h40,3'd1,8'h40,1,1,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h40,3'd2,8'h40,0,1,0,0));
    vq.push_back(mk(1,0,1,0,0,0,0,0,8'h40,3'd0,8'h00,0,0,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h40,3'd0,8'h00,0,0,0,0));
    // write_icw1 overrides a coincident INTA fall
    vq.push_back(mk(0,1,0,0,0,0,0,0,8'h40,3'd0,8'h00,0,0,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h40,3'd0,8'h00,0,0,0,0));
    vq.push_back(mk(0,0,1,0,0,0,0,0,8'h40,3'd0,8'h00,0,0,0,0));

    for (int i = 0; i < vq.size(); i++) begin
      reset = vq[i].rst; icw1 = vq[i].icw1; inta_n = vq[i].inta; rd = vq[i].rd;
      poll = vq[i].poll; cfg = vq[i].cfg; cs = vq[i].cs; cse = vq[i].cse; irq = vq[i].irq;
      step();
      chk($sformatf("row%0d", i), outs(),
          {vq[i].st, vq[i].iwa, vq[i].lat, vq[i].frz, vq[i].eoa, vq[i].eop});
    end
    reset = 1'b0; icw1 = 1'b0; poll = 1'b0; rd = 1'b0; cs = 1'b0; cse = 1'b0; cfg = 1'b0;

    // ACK1 held for a long time without an INTA rise
    irq = 8'h04; inta_n = 1'b0;
    step();
    chk("hold_enter", outs(), {3'd1, 8'h04, 1'b1, 1'b1, 1'b0, 1'b0});
    for (int k = 0; k < 30; k++) begin
      step();
      chk($sformatf("hold%0d", k), outs(), {3'd1, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0});
    end
    inta_n = 1'b1; step();
    chk("hold_ack2", outs(), {3'd2, 8'h04, 1'b0, 1'b1, 1'b0, 1'b0});
    inta_n = 1'b0; step();
    inta_n = 1'b1; step();
    chk("hold_end", outs(), {3'd0, 8'h04, 1'b0, 1'b0, 1'b1, 1'b0});
    step();
    chk("hold_eoa_once", outs(), {3'd0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0});

    // poll with nothing pending: no ISR latch, vector cleared, long read
    irq = 8'h00; poll = 1'b1; step(); poll = 1'b0;
    chk("poll0_enter", outs(), {3'd4, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0});
    rd = 1'b1; step();
    chk("poll0_rise", outs(), {3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("poll0_hold%0d", k), outs(), {3'd4, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});
    end
    rd = 1'b0; step();
    chk("poll0_end", outs(), {3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1});
    step();
    chk("poll0_eop_once", outs(), {3'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ack_control_sequencer.md
Name: ack_control_sequencer

Overview:
Synchronous control state machine that sequences the 8259A interrupt-acknowledge and poll datapath. It tracks INTA_n pulses and poll/read strobes and produces the control_state code consumed by the cascade/acknowledge data-output logic. It also produces the in-service latch strobe, the IRR freeze, and the captured ACK1 interrupt vector. It sits between the bus/read-write interface, the priority resolver and the acknowledge/cascade output logic.

Parameters:
None. State encoding is fixed: CTL_READY=3'b000, ACK1=3'b001, ACK2=3'b010, ACK3=3'b011, POLL=3'b100.

Ports:
clock  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
interrupt_acknowledge_n  input  1  INTA_n from CPU, already synchronised to clock
read  input  1  read strobe, active high, level
poll_command  input  1  one-cycle pulse: OCW3 with P=1 written
write_icw1  input  1  one-cycle pulse: ICW1 written (re-initialise)
u8086_or_mcs80_config  input  1  0 = 8086 (2 INTA pulses), 1 = MCS-80 (3 pulses)
cascade_slave  input  1  1 = device configured as slave
cascade_slave_enable  input  1  1 = slave addressed by CAS lines
interrupt  input  8  one-hot highest-priority request from the priority resolver; 0 = none
control_state  output  3  current state code
interrupt_when_ack1  output  8  interrupt captured at the start of ACK1
latch_in_service  output  1  one-cycle pulse: set ISR bit from interrupt_when_ack1 or interrupt
freeze  output  1  high while an acknowledge sequence is in progress; IRR must not update
end_of_acknowledge_sequence  output  1  one-cycle pulse on the final INTA rising edge
end_of_poll_command  output  1  one-cycle pulse at the end of the poll read

Behaviour:
- Edge detection:
  - Internal inta_prev register, reset value 1. fall = inta_prev & ~interrupt_acknowledge_n; rise = ~inta_prev & interrupt_acknowledge_n.
  - Internal read_prev register, reset value 0. read_rise and read_fall are defined the same way.
  - All transitions and pulses occur at the clock edge in which the edge is detected; outputs are visible the following cycle (1-cycle latency).
- Reset (and write_icw1, which has identical effect):
  - control_state=CTL_READY, interrupt_when_ack1=0, freeze=0, all pulse outputs 0, inta_prev=1, read_prev=0.
  - write_icw1 overrides every other event in the same cycle.
- CTL_READY:
  - On fall: go to ACK1, capture interrupt_when_ack1<=interrupt, freeze<=1.
  - latch_in_service pulses only if interrupt!=0 and (cascade_slave==0 or cascade_slave_enable==1). For a slave, cascade_slave_enable is sampled in the same cycle.
  - Else on poll_command: go to POLL.
  - fall and poll_command in the same cycle: fall wins and the poll is discarded.
- ACK1: on rise -> ACK2.
- ACK2: on rise:
  - If u8086_or_mcs80_config==0: go to CTL_READY, freeze<=0, end_of_acknowledge_sequence pulses.
  - Else: go to ACK3.
- ACK3: on rise -> CTL_READY, freeze<=0, end_of_acknowledge_sequence pulses.
- A falling edge inside ACK1/ACK2/ACK3 does not change state; only rises advance. No timeout: state holds indefinitely waiting for INTA.
- POLL:
  - On read_rise: latch_in_service pulses if interrupt!=0, and interrupt_when_ack1<=interrupt.
  - On read_fall: go to CTL_READY, end_of_poll_command pulses.
  - On fall while in POLL: abort the poll (no end_of_poll_command) and perform the CTL_READY-fall actions.
  - freeze stays 0 in POLL.
- Mode change: u8086_or_mcs80_config is sampled only at the ACK2 rise. Changing it mid-sequence affects only that decision.
- All pulse outputs are exactly one cycle wide and are never asserted together with reset.
- Illegal state codes (101-111) recover to CTL_READY on the next clock.

Test Plan:
- 8086 sequence:
  - Stimulus: reset, config=0, interrupt=8'h04, two INTA low pulses of 3 cycles each.
  - Required: control_state goes 000->001 (1 cycle after fall1) ->010 (after rise1) ->000 (after rise2).
  - Required: latch_in_service pulses once at fall1; interrupt_when_ack1=8'h04; freeze high from fall1 to rise2; end_of_acknowledge_sequence pulses once.
- MCS-80 sequence:
  - Stimulus: config=1, interrupt=8'h80, three INTA pulses.
  - Required: states 001,010,011,000 in order; end_of_acknowledge_sequence only after the third rise.
- Spurious/slave:
  - interrupt=0 at fall: enters ACK1, no latch_in_service, interrupt_when_ack1=0.
  - cascade_slave=1, cascade_slave_enable=0 with interrupt=8'h01: no latch_in_service, states still sequence.
- Poll:
  - Stimulus: poll_command pulse, then read high 2 cycles with interrupt=8'h10.
  - Required: state=100; latch_in_service at read rise; interrupt_when_ack1=8'h10; end_of_poll_command at read fall; state returns to 000.
- Priority collisions:
  - poll_command and INTA fall in the same cycle -> ACK1, POLL never entered.
  - INTA fall while in POLL -> ACK1, no end_of_poll_command.
- Reset/re-init mid-operation:
  - Assert write_icw1 (then reset) while in ACK2 with freeze=1.
  - Required: next cycle state=000, freeze=0, interrupt_when_ack1=0, no pulses.
  - Next INTA rise causes no transition.
